// File: rtl/day6_worksheet_engine.sv
// -----------------------------------------------------------------------------
// day6_worksheet_engine
//
// Streaming worksheet evaluator. Columns arrive one per handshake, top row
// first in each lane. Inside a block every row forms a decimal number from left
// to right (part 1), and every column forms a decimal number from top to
// bottom (part 2). Each block folds its numbers with + or *. The block values
// are then added into two running results.
//
// The column numbers are folded as the columns arrive. The row numbers are
// folded by a REDUCE pass that takes ROWS cycles and handles one row per
// cycle, so the datapath needs only one multiplier for any ROWS. No column is
// accepted during REDUCE.
//
// Optional build macro: DAY6_OVERFLOW_DETECT_EN
//   defined   -> overflow is a sticky flag that is set when any *10, add or
//                multiply exceeds DATA_W bits (results still wrap)
//   undefined -> overflow stays 0 and no wide-product checks are built
//
// Parameters:
//   ROWS     digit rows per column (>= 1)
//   DATA_W   width of accumulators and results
//   DIGIT_W  bits per BCD digit lane
//
// Ports:
//   clock         system clock
//   clear_n       asynchronous active-low reset
//   load          synchronous restart (zero all state, leave DONE)
//   col_valid     a column is offered
//   col_ready     the engine can accept a column (state ACCEPT)
//   col_digits    row r digit at [r*DIGIT_W +: DIGIT_W], row 0 = top
//   col_space     row r is blank in this column
//   block_start   first column of a block
//   block_plus    block op, 1 = add, 0 = multiply (sampled with block_start)
//   col_last      last column of a block
//   frame_last    last block of the worksheet (sampled with col_last)
//   part1_result  sum of the row-wise block values
//   part2_result  sum of the column-wise block values
//   done          worksheet complete
//   in_block      a block has started and its REDUCE pass has not ended
//   overflow      sticky arithmetic overflow (macro build only)
// -----------------------------------------------------------------------------
module day6_worksheet_engine #(
    parameter int ROWS    = 4,
    parameter int DATA_W  = 64,
    parameter int DIGIT_W = 4
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      load,
    input  logic                      col_valid,
    output logic                      col_ready,
    input  logic [ROWS*DIGIT_W-1:0]   col_digits,
    input  logic [ROWS-1:0]           col_space,
    input  logic                      block_start,
    input  logic                      block_plus,
    input  logic                      col_last,
    input  logic                      frame_last,
    output logic [DATA_W-1:0]         part1_result,
    output logic [DATA_W-1:0]         part2_result,
    output logic                      done,
    output logic                      in_block,
    output logic                      overflow
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Arithmetic helpers. Each one returns {overflow, value[DATA_W-1:0]}.
`ifdef DAY6_OVERFLOW_DETECT_EN
    localparam int WIDE_W = DATA_W + DIGIT_W + 4;
    localparam int PROD_W = 2 * DATA_W;

    function automatic logic [DATA_W:0] mac10(input logic [DATA_W-1:0] a,
                                              input logic [DIGIT_W-1:0] d);
        logic [WIDE_W-1:0] wide;
        wide = (WIDE_W'(a) << 3'd3) + (WIDE_W'(a) << 3'd1) + WIDE_W'(d);
        return {|wide[WIDE_W-1:DATA_W], wide[DATA_W-1:0]};
    endfunction

    function automatic logic [DATA_W:0] mul_w(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [PROD_W-1:0] wide;
        wide = PROD_W'(a) * PROD_W'(b);
        return {|wide[PROD_W-1:DATA_W], wide[DATA_W-1:0]};
    endfunction

    function automatic logic [DATA_W:0] add_w(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction
`else
    function automatic logic [DATA_W:0] mac10(input logic [DATA_W-1:0] a,
                                              input logic [DIGIT_W-1:0] d);
        return {1'b0, (a << 3'd3) + (a << 3'd1) + DATA_W'(d)};
    endfunction

    function automatic logic [DATA_W:0] mul_w(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        return {1'b0, a * b};
    endfunction

    function automatic logic [DATA_W:0] add_w(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        return {1'b0, a + b};
    endfunction
`endif

    function automatic logic [DATA_W:0] op_w(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic plus);
        if (plus) begin
            return add_w(a, b);
        end else begin
            return mul_w(a, b);
        end
    endfunction

    // Registered state
    state_t              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic                frame_last_r;
    logic                done_r;
    logic                in_block_r;
    logic                op_plus_r;
    logic [DATA_W-1:0]   row_acc_r [ROWS];
    logic [ROWS-1:0]     row_seen_r;
    logic                blk_seen_r;
    logic [DATA_W-1:0]   p2_blk_r;
    logic [DATA_W-1:0]   p1_blk_r;
    logic                p1_seen_r;
    logic [DATA_W-1:0]   part1_r;
    logic [DATA_W-1:0]   part2_r;
    logic                ovf_r;

    // Combinational next values
    logic                accept_s;
    logic                last_idx_s;
    logic                op_s;
    logic [DATA_W-1:0]   row_acc_nx_s [ROWS];
    logic [ROWS-1:0]     row_seen_nx_s;
    logic [DATA_W-1:0]   col_num_s;
    logic                col_any_s;
    logic [DATA_W-1:0]   p2_nx_s;
    logic                blk_seen_nx_s;
    logic                ovf_col_s;
    logic [DATA_W-1:0]   sel_acc_s;
    logic                sel_seen_s;
    logic [DATA_W-1:0]   p1_nx_s;
    logic                ovf_red_s;
    logic [DATA_W-1:0]   sum1_s;
    logic [DATA_W-1:0]   sum2_s;
    logic                ovf_sum_s;

    assign col_ready    = (state_r == ST_ACCEPT);
    assign accept_s     = col_valid & col_ready;
    assign last_idx_s   = (idx_r == LAST_IDX);
    assign done         = done_r;
    assign in_block     = in_block_r;
    assign part1_result = part1_r;
    assign part2_result = part2_r;
    assign overflow     = ovf_r;

    // Column intake: update the row accumulators and fold the column number into the block.
    // On block_start the per-block state is taken as zero before this column is applied.
    always_comb begin
        logic [DATA_W:0]      t_row;
        logic [DATA_W:0]      t_col;
        logic [DATA_W:0]      t_blk;
        logic [DIGIT_W-1:0]   dig;
        logic [DATA_W-1:0]    base_acc;
        logic [DATA_W-1:0]    p2_base;
        logic                 blk_seen_base;
        t_row         = '0;
        t_col         = '0;
        t_blk         = '0;
        dig           = '0;
        base_acc      = '0;
        col_num_s     = '0;
        col_any_s     = 1'b0;
        ovf_col_s     = 1'b0;
        row_seen_nx_s = '0;
        op_s          = block_start ? block_plus : op_plus_r;
        for (int r = 0; r < ROWS; r++) begin
            dig      = col_digits[r*DIGIT_W +: DIGIT_W];
            base_acc = block_start ? {DATA_W{1'b0}} : row_acc_r[r];
            if (col_space[r]) begin
                row_acc_nx_s[r]  = base_acc;
                row_seen_nx_s[r] = block_start ? 1'b0 : row_seen_r[r];
            end else begin
                t_row            = mac10(base_acc, dig);
                row_acc_nx_s[r]  = t_row[DATA_W-1:0];
                row_seen_nx_s[r] = 1'b1;
                t_col            = mac10(col_num_s, dig);
                col_num_s        = t_col[DATA_W-1:0];
                col_any_s        = 1'b1;
                ovf_col_s        = ovf_col_s | t_row[DATA_W] | t_col[DATA_W];
            end
        end
        p2_base       = block_start ? {DATA_W{1'b0}} : p2_blk_r;
        blk_seen_base = block_start ? 1'b0 : blk_seen_r;
        t_blk         = op_w(p2_base, col_num_s, op_s);
        if (!col_any_s) begin
            // An all-space column has no effect on part 2.
            p2_nx_s       = p2_base;
            blk_seen_nx_s = blk_seen_base;
        end else if (blk_seen_base) begin
            p2_nx_s       = t_blk[DATA_W-1:0];
            blk_seen_nx_s = 1'b1;
            ovf_col_s     = ovf_col_s | t_blk[DATA_W];
        end else begin
            p2_nx_s       = col_num_s;
            blk_seen_nx_s = 1'b1;
        end
    end

    // Reduce step: fold row idx into the part 1 block value and form the final result sums.
    always_comb begin
        logic [DATA_W:0] t_op;
        logic [DATA_W:0] t_s1;
        logic [DATA_W:0] t_s2;
        sel_acc_s  = '0;
        sel_seen_s = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            sel_acc_s  = (idx_r == IDX_W'(r)) ? row_acc_r[r]  : sel_acc_s;
            sel_seen_s = (idx_r == IDX_W'(r)) ? row_seen_r[r] : sel_seen_s;
        end
        t_op = op_w(p1_blk_r, sel_acc_s, op_plus_r);
        if (!sel_seen_s) begin
            p1_nx_s   = p1_blk_r;
            ovf_red_s = 1'b0;
        end else if (p1_seen_r) begin
            p1_nx_s   = t_op[DATA_W-1:0];
            ovf_red_s = t_op[DATA_W];
        end else begin
            p1_nx_s   = sel_acc_s;
            ovf_red_s = 1'b0;
        end
        t_s1      = add_w(part1_r, p1_nx_s);
        t_s2      = add_w(part2_r, p2_blk_r);
        sum1_s    = t_s1[DATA_W-1:0];
        sum2_s    = t_s2[DATA_W-1:0];
        ovf_sum_s = t_s1[DATA_W] | t_s2[DATA_W];
    end

    // Control FSM: ACCEPT -> REDUCE (ROWS cycles) -> ACCEPT or DONE. load overrides all.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r      <= ST_ACCEPT;
            idx_r        <= '0;
            frame_last_r <= 1'b0;
            done_r       <= 1'b0;
            in_block_r   <= 1'b0;
        end else if (load) begin
            state_r      <= ST_ACCEPT;
            idx_r        <= '0;
            frame_last_r <= 1'b0;
            done_r       <= 1'b0;
            in_block_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCEPT: begin
                    if (accept_s) begin
                        if (block_start) begin
                            in_block_r <= 1'b1;
                        end
                        if (col_last) begin
                            state_r      <= ST_REDUCE;
                            idx_r        <= '0;
                            frame_last_r <= frame_last;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (last_idx_s) begin
                        idx_r      <= '0;
                        in_block_r <= 1'b0;
                        if (frame_last_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ACCEPT;
                        end
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_ACCEPT;
                    idx_r   <= '0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: block accumulators, running results and the sticky overflow flag.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int r = 0; r < ROWS; r++) begin
                row_acc_r[r] <= '0;
            end
            row_seen_r <= '0;
            blk_seen_r <= 1'b0;
            op_plus_r  <= 1'b0;
            p2_blk_r   <= '0;
            p1_blk_r   <= '0;
            p1_seen_r  <= 1'b0;
            part1_r    <= '0;
            part2_r    <= '0;
            ovf_r      <= 1'b0;
        end else if (load) begin
            for (int r = 0; r < ROWS; r++) begin
                row_acc_r[r] <= '0;
            end
            row_seen_r <= '0;
            blk_seen_r <= 1'b0;
            op_plus_r  <= 1'b0;
            p2_blk_r   <= '0;
            p1_blk_r   <= '0;
            p1_seen_r  <= 1'b0;
            part1_r    <= '0;
            part2_r    <= '0;
            ovf_r      <= 1'b0;
        end else if (accept_s) begin
            for (int r = 0; r < ROWS; r++) begin
                row_acc_r[r] <= row_acc_nx_s[r];
            end
            row_seen_r <= row_seen_nx_s;
            blk_seen_r <= blk_seen_nx_s;
            p2_blk_r   <= p2_nx_s;
            op_plus_r  <= op_s;
            // The part 1 fold starts from empty for each REDUCE pass.
            p1_blk_r   <= '0;
            p1_seen_r  <= 1'b0;
            ovf_r      <= ovf_r | ovf_col_s;
        end else if (state_r == ST_REDUCE) begin
            p1_blk_r  <= p1_nx_s;
            p1_seen_r <= p1_seen_r | sel_seen_s;
            if (last_idx_s) begin
                part1_r <= sum1_s;
                part2_r <= sum2_s;
                ovf_r   <= ovf_r | ovf_red_s | ovf_sum_s;
            end else begin
                ovf_r   <= ovf_r | ovf_red_s;
            end
        end
    end

endmodule

// File: tb/tb_day6_worksheet_engine.sv
// Self-checking bench for day6_worksheet_engine (ROWS=4, DATA_W=64, DIGIT_W=4).
module tb_day6_worksheet_engine;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        load;
    logic        col_valid;
    logic        col_ready;
    logic [15:0] col_digits;
    logic [3:0]  col_space;
    logic        block_start;
    logic        block_plus;
    logic        col_last;
    logic        frame_last;
    logic [63:0] part1_result;
    logic [63:0] part2_result;
    logic        done;
    logic        in_block;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    bit exp_ovf  = 1'b0;

    logic [63:0] run1;
    logic [63:0] run2;

    // Columns of the current block for the reference model
    logic [15:0] cd [0:31];
    logic [3:0]  cs [0:31];
    int          nc;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  sp;
        bit          bs;
        bit          bp;
        bit          cl;
        bit          fl;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    day6_worksheet_engine dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .load         (load),
        .col_valid    (col_valid),
        .col_ready    (col_ready),
        .col_digits   (col_digits),
        .col_space    (col_space),
        .block_start  (block_start),
        .block_plus   (block_plus),
        .col_last     (col_last),
        .frame_last   (frame_last),
        .part1_result (part1_result),
        .part2_result (part2_result),
        .done         (done),
        .in_block     (in_block),
        .overflow     (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Column text: character r is row r, ' ' is a blank cell.
    task automatic push_col(input string s, input bit bs, input bit bp, input bit cl,
                            input bit fl, input logic [63:0] e1, input logic [63:0] e2);
        vec_t v;
        byte  ch;
        v.dig = '0;
        v.sp  = '0;
        for (int r = 0; r < 4; r++) begin
            ch = s[r];
            if (ch == " ") begin
                v.sp[r] = 1'b1;
            end else begin
                v.dig[r*4 +: 4] = 4'(ch - "0");
            end
        end
        v.bs = bs; v.bp = bp; v.cl = cl; v.fl = fl; v.e1 = e1; v.e2 = e2;
        vecs.push_back(v);
    endtask

    task automatic send_col(input logic [15:0] dig, input logic [3:0] sp, input bit bs,
                            input bit bp, input bit cl, input bit fl);
        bit ok;
        bit rdy;
        int k;
        col_digits  = dig;
        col_space   = sp;
        block_start = bs;
        block_plus  = bp;
        col_last    = cl;
        frame_last  = fl;
        col_valid   = 1'b1;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 50) begin
            rdy = col_ready;
            @(posedge clock);
            #1;
            ok = rdy;
            k++;
        end
        col_valid = 1'b0;
        chk("accepted", 64'(ok), 64'd1);
    endtask

    task automatic finish_block(input logic [63:0] e1, input logic [63:0] e2,
                                input bit fl, input string name);
        int k;
        k = 0;
        while (!(col_ready || done) && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk({name, "_latency"}, 64'(k), 64'd4);
        chk({name, "_part1"}, part1_result, e1);
        chk({name, "_part2"}, part2_result, e2);
        chk({name, "_done"}, 64'(done), 64'(fl));
        chk({name, "_in_block"}, 64'(in_block), 64'd0);
        chk({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        if (fl) begin
            load = 1'b1;
            @(posedge clock);
            #1;
            load = 1'b0;
            chk({name, "_load_done"}, 64'(done), 64'd0);
            chk({name, "_load_part1"}, part1_result, 64'd0);
            chk({name, "_load_ovf"}, 64'(overflow), 64'd0);
            run1 = '0;
            run2 = '0;
        end
    endtask

    function automatic logic [63:0] opf(input logic [63:0] a, input logic [63:0] b,
                                        input bit plus);
        return plus ? (a + b) : (a * b);
    endfunction

    // Reference: read each row left to right and each column top to bottom as decimal numbers, then fold.
    task automatic model_block(input bit plus, output logic [63:0] p1, output logic [63:0] p2);
        logic [63:0] num;
        bit          seen;
        bit          first;
        p1 = '0;
        first = 1'b1;
        for (int r = 0; r < 4; r++) begin
            num = '0;
            seen = 1'b0;
            for (int c = 0; c < nc; c++) begin
                if (!cs[c][r]) begin
                    num  = num * 64'd10 + 64'(cd[c][r*4 +: 4]);
                    seen = 1'b1;
                end
            end
            if (seen) begin
                p1 = first ? num : opf(p1, num, plus);
                first = 1'b0;
            end
        end
        p2 = '0;
        first = 1'b1;
        for (int c = 0; c < nc; c++) begin
            num = '0;
            seen = 1'b0;
            for (int r = 0; r < 4; r++) begin
                if (!cs[c][r]) begin
                    num  = num * 64'd10 + 64'(cd[c][r*4 +: 4]);
                    seen = 1'b1;
                end
            end
            if (seen) begin
                p2 = first ? num : opf(p2, num, plus);
                first = 1'b0;
            end
        end
    endtask

    task automatic send_block(input bit plus, input bit fl, input bit gaps, input string name);
        logic [63:0] p1;
        logic [63:0] p2;
        for (int c = 0; c < nc; c++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clock);
                #1;
            end
            send_col(cd[c], cs[c], c == 0, plus, c == nc - 1, fl && (c == nc - 1));
        end
        model_block(plus, p1, p2);
        run1 = run1 + p1;
        run2 = run2 + p2;
        finish_block(run1, run2, fl, name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_n = 1'b0; load = 1'b0; col_valid = 1'b0; col_digits = '0; col_space = '0;
        block_start = 1'b0; block_plus = 1'b0; col_last = 1'b0; frame_last = 1'b0;
        run1 = '0; run2 = '0; nc = 0;

        // Reset state
        repeat (3) @(posedge clock);
        #3 clear_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_ready", 64'(col_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_part1", part1_result, 64'd0);
        chk("rst_part2", part2_result, 64'd0);
        chk("rst_in_block", 64'(in_block), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Table: single multiply block, the full worksheet, single-column add block
        push_col("1   ", 1, 0, 0, 0, 0, 0);
        push_col("24  ", 0, 0, 0, 0, 0, 0);
        push_col("356 ", 0, 0, 1, 1, 64'd33210, 64'd8544);
        push_col("1   ", 1, 0, 0, 0, 0, 0);
        push_col("24  ", 0, 0, 0, 0, 0, 0);
        push_col("356 ", 0, 0, 1, 0, 64'd33210, 64'd8544);
        push_col("369 ", 1, 1, 0, 0, 0, 0);
        push_col("248 ", 0, 1, 0, 0, 0, 0);
        push_col("8   ", 0, 1, 1, 0, 64'd33700, 64'd9169);
        push_col(" 32 ", 1, 0, 0, 0, 0, 0);
        push_col("581 ", 0, 0, 0, 0, 0, 0);
        push_col("175 ", 0, 0, 1, 0, 64'd4277155, 64'd3262769);
        push_col("623 ", 1, 1, 0, 0, 0, 0);
        push_col("431 ", 0, 1, 0, 0, 0, 0);
        push_col("  4 ", 0, 1, 1, 1, 64'd4277556, 64'd3263827);
        push_col("78 9", 1, 1, 1, 1, 64'd24, 64'd789);
        for (int i = 0; i < vecs.size(); i++) begin
            send_col(vecs[i].dig, vecs[i].sp, vecs[i].bs, vecs[i].bp, vecs[i].cl, vecs[i].fl);
            if (vecs[i].bs && !vecs[i].cl) begin
                chk("table_in_block", 64'(in_block), 64'd1);
            end
            if (vecs[i].cl) begin
                finish_block(vecs[i].e1, vecs[i].e2, vecs[i].fl, "table");
            end
        end

        // Reset held low in the middle of REDUCE
        send_col(16'h0007, 4'b1110, 1, 1, 1, 0);
        finish_block(64'd7, 64'd7, 0, "pre_reset");
        send_col(16'h0001, 4'b1110, 1, 0, 1, 0);
        @(posedge clock); #1;
        chk("mid_reduce_ready", 64'(col_ready), 64'd0);
        #2 clear_n = 1'b0;
        #1;
        chk("async_rst_in_block", 64'(in_block), 64'd0);
        repeat (2) @(posedge clock);
        #3 clear_n = 1'b1;
        #1;
        chk("rel_ready", 64'(col_ready), 64'd1);
        chk("rel_done", 64'(done), 64'd0);
        chk("rel_part1", part1_result, 64'd0);
        chk("rel_part2", part2_result, 64'd0);
        chk("rel_in_block", 64'(in_block), 64'd0);
        @(posedge clock); #1;

        // Backpressure through REDUCE, then load on REDUCE cycle 2
        send_col(16'h0001, 4'b1110, 1, 1, 0, 0);
        send_col(16'h0002, 4'b1110, 0, 1, 1, 0);
        col_digits = 16'h0005; col_space = 4'b1110; block_start = 1'b1; block_plus = 1'b1;
        col_last = 1'b1; frame_last = 1'b1; col_valid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("bp_ready_low", 64'(col_ready), 64'd0);
        chk("bp_in_block", 64'(in_block), 64'd1);
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
        chk("abort_part1", part1_result, 64'd0);
        chk("abort_part2", part2_result, 64'd0);
        chk("abort_ready", 64'(col_ready), 64'd1);
        chk("abort_in_block", 64'(in_block), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        send_col(16'h0005, 4'b1110, 1, 1, 1, 1);
        finish_block(64'd5, 64'd5, 1, "after_abort");

        // Randomized worksheets against the reference model
        for (int w = 0; w < 8; w++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                nc = $urandom_range(1, 4);
                for (int c = 0; c < nc; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        cs[c][r] = ($urandom_range(0, 2) == 0);
                        cd[c][r*4 +: 4] = 4'($urandom_range(0, 9));
                    end
                    if ($urandom_range(0, 7) == 0) begin
                        cs[c] = 4'b1111;
                    end
                end
                send_block(1'($urandom_range(0, 1)), b == nb - 1, 1'b1, "rand");
            end
        end

        // A 20-digit row exceeds 64 bits; the results wrap
        nc = 20;
        for (int c = 0; c < nc; c++) begin
            cs[c] = 4'b1110;
            cd[c] = 16'h0009;
        end
`ifdef DAY6_OVERFLOW_DETECT_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        send_block(1'b0, 1'b1, 1'b0, "wide");
        exp_ovf = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
